// File: rtl/apb_payload_regs.sv
// APB slave collecting a multi-word payload and byte count for the
// packet-transmit logic, locked until the consumer accepts it.
module apb_payload_regs #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_PAYLOAD = 4,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_WIDTH  = 8,
  localparam int SIZE_W =
    $clog2(NUM_PAYLOAD * DATA_WIDTH / 8 + 1)
) (
  input  logic                              pclk,
  input  logic                              preset_n,
  input  logic                              psel,
  input  logic                              penable,
  input  logic                              pwrite,
  input  logic [ADDR_WIDTH-1:0]             paddr,
  input  logic [DATA_WIDTH-1:0]             pwdata,
  input  logic [DATA_WIDTH/8-1:0]           pstrb,
  output logic [DATA_WIDTH-1:0]             prdata,
  output logic                              pready,
  output logic                              pslverr,
  output logic [NUM_PAYLOAD*DATA_WIDTH-1:0] payload,
  output logic [SIZE_W-1:0]                 data_size,
  output logic                              payload_valid,
  input  logic                              payload_ready
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int MAXB = NUM_PAYLOAD * NB;
  localparam int IW   = ADDR_WIDTH - 2;

  localparam logic [IW-1:0] SIZE_IDX = IW'(NUM_PAYLOAD);
  localparam logic [IW-1:0] STAT_IDX = IW'(NUM_PAYLOAD + 1);
  localparam logic [1:0]    WS       = 2'(WAIT_STATES);
  localparam logic [DATA_WIDTH-1:0] MAXV = DATA_WIDTH'(MAXB);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                state;
  logic [1:0]            wcnt;
  logic [DATA_WIDTH-1:0] pay_q [NUM_PAYLOAD];
  logic [SIZE_W-1:0]     size_q;
  logic                  valid_q;

  logic [IW-1:0]         idx;
  logic                  is_pay;
  logic                  is_size;
  logic                  is_stat;
  logic                  size_big;
  logic                  err;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rdata;

  assign idx      = paddr[ADDR_WIDTH-1:2];
  assign is_pay   = idx < SIZE_IDX;
  assign is_size  = idx == SIZE_IDX;
  assign is_stat  = idx == STAT_IDX;
  assign size_big = pwdata > MAXV;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state <= ACCESS;
            wcnt  <= WS;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (!penable) begin
            wcnt <= WS;
          end else if (wcnt != 2'd0) begin
            wcnt <= wcnt - 2'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pready = (state == ACCESS) && psel &&
                  penable && (wcnt == 2'd0);

  // Lock check uses the registered valid, so a write landing on the
  // handshake edge still errors.
  always_comb begin
    err = 1'b0;
    if (!(is_pay || is_size || is_stat))
      err = 1'b1;
    if (pwrite && is_stat)
      err = 1'b1;
    if (pwrite && (is_pay || is_size) && valid_q)
      err = 1'b1;
    if (pwrite && is_size && size_big)
      err = 1'b1;
  end

  assign pslverr = pready && err;
  assign wr_en   = pready && pwrite && !err;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_stat: rdata = DATA_WIDTH'(valid_q);
      is_size: rdata = DATA_WIDTH'(size_q);
      is_pay: begin
        for (int i = 0; i < NUM_PAYLOAD; i++) begin
          if (idx == IW'(i))
            rdata = pay_q[i];
        end
      end
      default: rdata = '0;
    endcase
  end

  assign prdata = (pready && !pwrite) ? rdata : '0;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_PAYLOAD; i++)
        pay_q[i] <= '0;
    end else if (wr_en && is_pay) begin
      for (int i = 0; i < NUM_PAYLOAD; i++) begin
        if (idx == IW'(i)) begin
          for (int b = 0; b < NB; b++) begin
            if (pstrb[b])
              pay_q[i][b*8 +: 8] <= pwdata[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      size_q  <= '0;
      valid_q <= 1'b0;
    end else if (wr_en && is_size) begin
      size_q  <= pwdata[SIZE_W-1:0];
      valid_q <= 1'b1;
    end else if (valid_q && payload_ready) begin
      valid_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_PAYLOAD; g++) begin : g_pay
    assign payload[g*DATA_WIDTH +: DATA_WIDTH] = pay_q[g];
  end

  assign data_size     = size_q;
  assign payload_valid = valid_q;

endmodule

// File: tb/tb_apb_payload_regs.sv
// Scoreboard bench for apb_payload_regs: stimulus queues expected
// responses, a monitor checks each pready cycle.
module tb_apb_payload_regs;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [7:0]  pwdata;
  logic [0:0]  pstrb;
  logic [7:0]  prdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] payload;
  logic [2:0]  data_size;
  logic        payload_valid;
  logic        payload_ready;

  int checks   = 0;
  int failures = 0;
  int acnt     = 0;

  typedef struct {
    logic [7:0] rd;
    logic       err;
  } exp_t;

  exp_t sb[$];

  apb_payload_regs #(
    .DATA_WIDTH (8),
    .NUM_PAYLOAD(4),
    .WAIT_STATES(2),
    .ADDR_WIDTH (8)
  ) dut (
    .pclk         (pclk),
    .preset_n     (preset_n),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .pstrb        (pstrb),
    .prdata       (prdata),
    .pready       (pready),
    .pslverr      (pslverr),
    .payload      (payload),
    .data_size    (data_size),
    .payload_valid(payload_valid),
    .payload_ready(payload_ready)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per pready cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (psel && penable) acnt++;
      else acnt = 0;
      if (pready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pready: got 1 want 0");
        end else begin
          e = sb.pop_front();
          chk("prdata", 32'(prdata), 32'(e.rd));
          chk("pslverr", 32'(pslverr), 32'(e.err));
          chk("access_len", acnt, 3);
        end
        acnt = 0;
      end
    end
  end

  task automatic xfer(input logic wr,
                      input logic [7:0] addr,
                      input logic [7:0] data,
                      input logic [7:0] exp_rd,
                      input logic exp_err,
                      input logic strb = 1'b1);
    int n;
    sb.push_back('{rd: exp_rd, err: exp_err});
    @(posedge pclk);
    #1;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!pready && n < 10);
    if (!pready) begin
      checks++;
      failures++;
      $display("FAIL pready_timeout: got 0 want 1");
    end
    @(posedge pclk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d,
                    input logic e, input logic s = 1'b1);
    xfer(1'b1, a, d, 8'h00, e, s);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] d,
                    input logic e);
    xfer(1'b0, a, 8'h00, d, e);
  endtask

  task automatic pulse_ready();
    @(posedge pclk);
    #1 payload_ready = 1'b1;
    @(posedge pclk);
    #1 payload_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_prdata"}, 32'(prdata), 0);
    chk({tag, "_pready"}, 32'(pready), 0);
    chk({tag, "_pslverr"}, 32'(pslverr), 0);
    chk({tag, "_payload"}, payload, 0);
    chk({tag, "_size"}, 32'(data_size), 0);
    chk({tag, "_valid"}, 32'(payload_valid), 0);
  endtask

  initial begin
    preset_n      = 1'b0;
    psel          = 1'b0;
    penable       = 1'b0;
    pwrite        = 1'b0;
    paddr         = '0;
    pwdata        = '0;
    pstrb         = '0;
    payload_ready = 1'b0;
    repeat (3) @(posedge pclk);
    #1 preset_n = 1'b1;
    @(negedge pclk);
    chk_reset_vals("rst");

    // Payload writes and read-back
    wr(8'h00, 8'hA5, 1'b0);
    wr(8'h04, 8'h3C, 1'b0);
    rd(8'h00, 8'hA5, 1'b0);
    rd(8'h04, 8'h3C, 1'b0);
    chk("payload_lo", 32'(payload[15:0]), 32'h3CA5);
    wr(8'h08, 8'h77, 1'b0, 1'b0);
    rd(8'h08, 8'h00, 1'b0);

    // Zero size is legal and still raises valid
    wr(8'h10, 8'h00, 1'b0);
    chk("valid_size0", 32'(payload_valid), 1);
    pulse_ready();
    chk("valid_clr0", 32'(payload_valid), 0);

    // Size write, lock, handshake
    wr(8'h10, 8'h02, 1'b0);
    chk("valid_set", 32'(payload_valid), 1);
    chk("size_2", 32'(data_size), 2);
    rd(8'h14, 8'h01, 1'b0);
    wr(8'h00, 8'hFF, 1'b1);
    chk("locked_byte0", 32'(payload[7:0]), 32'hA5);
    wr(8'h10, 8'h01, 1'b1);
    chk("locked_size", 32'(data_size), 2);
    pulse_ready();
    chk("valid_clr", 32'(payload_valid), 0);
    rd(8'h14, 8'h00, 1'b0);
    chk("size_held", 32'(data_size), 2);
    rd(8'h10, 8'h02, 1'b0);

    // Oversize
    wr(8'h10, 8'h05, 1'b1);
    chk("size_unchg", 32'(data_size), 2);
    chk("valid_stays0", 32'(payload_valid), 0);

    // Unmapped read, STATUS write
    rd(8'h18, 8'h00, 1'b1);
    wr(8'h14, 8'h01, 1'b1);
    chk("stat_wr_valid", 32'(payload_valid), 0);

    // Aborted transfer: no pready, no update
    @(posedge pclk);
    #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h08; pwdata = 8'h99; pstrb = 1'b1;
    @(posedge pclk);
    #1 penable = 1'b1;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
    repeat (4) @(posedge pclk);
    chk("abort_payload", 32'(payload[23:16]), 0);
    rd(8'h08, 8'h00, 1'b0);

    // Reset mid-access
    @(posedge pclk);
    #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h08; pwdata = 8'h99; pstrb = 1'b1;
    @(posedge pclk);
    #1 penable = 1'b1;
    @(posedge pclk);
    #1 preset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge pclk);
    @(posedge pclk);
    #1 preset_n = 1'b1;
    repeat (4) @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk_reset_vals("post");
    rd(8'h00, 8'h00, 1'b0);

    repeat (3) @(posedge pclk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
